// File: rtl/wordle_pkg.sv
// Shared constants for the Wordle scorer and the game state machine that drives it.
package wordle_pkg;

  localparam int NLET     = 5;
  localparam int LETTER_W = 8;

  // Per-position feedback codes; 2'b11 is never produced.
  localparam logic [1:0] FB_GRAY   = 2'b00;
  localparam logic [1:0] FB_YELLOW = 2'b01;
  localparam logic [1:0] FB_GREEN  = 2'b10;

  // One-hot scorer states.
  typedef enum logic [3:0] {
    QI    = 4'b0001,
    QG    = 4'b0010,
    QY    = 4'b0100,
    QDONE = 4'b1000
  } state_t;

endpackage

// File: rtl/wordle_scorer_if.sv
// Request/result bundle between the game state machine (master) and the scorer (slave).
//
// Handshake: Start is a request level sampled only while the scorer is idle;
// the edge that sees it latches guess/answer. Done then stays high with
// feedback/win stable until Ack is sampled high, which returns the scorer to
// idle on that edge. Start in any other state and Ack outside Done are ignored,
// and when both are high with Done, Ack wins.
interface wordle_scorer_if #(
  parameter int LETTER_W = wordle_pkg::LETTER_W
);
  localparam int WORD_W = wordle_pkg::NLET * LETTER_W;
  localparam int FB_W   = 2 * wordle_pkg::NLET;

  logic              Start;
  logic              Ack;
  logic [WORD_W-1:0] guess;
  logic [WORD_W-1:0] answer;
  logic              Busy;
  logic              Done;
  logic [FB_W-1:0]   feedback;
  logic              win;
  logic              q_I;
  logic              q_G;
  logic              q_Y;
  logic              q_Done;

  modport master (
    output Start, Ack, guess, answer,
    input  Busy, Done, feedback, win, q_I, q_G, q_Y, q_Done
  );

  modport slave (
    input  Start, Ack, guess, answer,
    output Busy, Done, feedback, win, q_I, q_G, q_Y, q_Done
  );
endinterface

// File: rtl/wordle_scorer.sv
// Sequential Wordle scorer: 5-cycle green pass, 25-cycle yellow pass, fixed 30-edge latency.
module wordle_scorer #(
  parameter int LETTER_W = wordle_pkg::LETTER_W
) (
  input logic           Clk,
  input logic           reset,
  wordle_scorer_if.slave bus
);
  import wordle_pkg::*;

  localparam int WORD_W = NLET * LETTER_W;
  localparam int LAST   = NLET - 1;

  state_t              state;
  state_t              state_next;
  logic [WORD_W-1:0]   g_q;
  logic [WORD_W-1:0]   a_q;
  logic [2*NLET-1:0]   fb_q;
  logic [NLET-1:0]     used_q;
  logic [2:0]          i_q;
  logic [2:0]          j_q;

  logic [LETTER_W-1:0] g_i;
  logic [LETTER_W-1:0] a_i;
  logic [LETTER_W-1:0] a_j;
  logic [1:0]          fb_i;
  logic                used_j;
  logic                last_i;
  logic                last_j;

  // Position 0 sits in the most significant letter slot.
  function automatic logic [LETTER_W-1:0] letter_at(input logic [WORD_W-1:0] w,
                                                   input logic [2:0] idx);
    letter_at = '0;
    for (int k = 0; k < NLET; k++)
      if (idx == 3'(k)) letter_at = w[(LAST-k)*LETTER_W +: LETTER_W];
  endfunction

  function automatic logic [1:0] fb_at(input logic [2*NLET-1:0] f, input logic [2:0] idx);
    fb_at = FB_GRAY;
    for (int k = 0; k < NLET; k++)
      if (idx == 3'(k)) fb_at = f[(LAST-k)*2 +: 2];
  endfunction

  // Operand selection for the current (i, j) position pair.
  always_comb begin
    g_i    = letter_at(g_q, i_q);
    a_i    = letter_at(a_q, i_q);
    a_j    = letter_at(a_q, j_q);
    fb_i   = fb_at(fb_q, i_q);
    used_j = 1'b0;
    for (int k = 0; k < NLET; k++)
      if (j_q == 3'(k)) used_j = used_q[k];
    last_i = (i_q == 3'(LAST));
    last_j = (j_q == 3'(LAST));
  end

  // State register.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) state <= QI;
    else        state <= state_next;
  end

  // Next-state logic; any non-legal encoding falls back to idle.
  always_comb begin
    state_next = QI;
    case (state)
      QI:      state_next = bus.Start ? QG : QI;
      QG:      state_next = last_i ? QY : QG;
      QY:      state_next = (last_i && last_j) ? QDONE : QY;
      QDONE:   state_next = bus.Ack ? QI : QDONE;
      default: state_next = QI;
    endcase
  end

  // Outputs decoded from the state and the feedback register.
  always_comb begin
    bus.Busy     = (state == QG) || (state == QY);
    bus.Done     = (state == QDONE);
    bus.feedback = fb_q;
    bus.win      = (state == QDONE) && (fb_q == {NLET{FB_GREEN}});
    bus.q_I      = (state == QI);
    bus.q_G      = (state == QG);
    bus.q_Y      = (state == QY);
    bus.q_Done   = (state == QDONE);
  end

  // Datapath: latch words on accept, then walk greens and yellows one compare per cycle.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      g_q    <= '0;
      a_q    <= '0;
      fb_q   <= '0;
      used_q <= '0;
      i_q    <= '0;
      j_q    <= '0;
    end else begin
      case (state)
        QI: begin
          if (bus.Start) begin
            g_q    <= bus.guess;
            a_q    <= bus.answer;
            fb_q   <= '0;
            used_q <= '0;
            i_q    <= '0;
            j_q    <= '0;
          end
        end
        QG: begin
          if (g_i == a_i) begin
            for (int k = 0; k < NLET; k++)
              if (i_q == 3'(k)) begin
                fb_q[(LAST-k)*2 +: 2] <= FB_GREEN;
                used_q[k]             <= 1'b1;
              end
          end
          i_q <= last_i ? 3'd0 : i_q + 3'd1;
          j_q <= 3'd0;
        end
        QY: begin
          // Greens were all claimed first, so a yellow can only take a still-free answer letter.
          if ((fb_i == FB_GRAY) && !used_j && (g_i == a_j)) begin
            for (int k = 0; k < NLET; k++) begin
              if (i_q == 3'(k)) fb_q[(LAST-k)*2 +: 2] <= FB_YELLOW;
              if (j_q == 3'(k)) used_q[k] <= 1'b1;
            end
          end
          if (last_j) begin
            j_q <= 3'd0;
            i_q <= last_i ? 3'd0 : i_q + 3'd1;
          end else begin
            j_q <= j_q + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wordle_scorer.sv
// Directed bench for wordle_scorer: driver issues requests, monitor scores results from a queue.
module tb_wordle_scorer;

  logic Clk   = 1'b0;
  logic reset = 1'b0;

  wordle_scorer_if bus ();

  wordle_scorer dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and edge counter.
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // Expected {win, feedback} per accepted request, plus the negedge count just before its accept edge.
  logic [10:0] exp_q[$];
  int          start_q[$];
  logic [10:0] held      = '0;
  int          st        = 0;
  logic        done_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare each new result, then keep checking it stays stable while Done is high.
  always @(negedge Clk) begin
    if (reset && bus.Done) begin
      if (!done_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 expected=0 at cycle %0d", cyc);
        end else begin
          held = exp_q.pop_front();
          st   = start_q.pop_front();
          chk("feedback", 32'(bus.feedback), 32'(held[9:0]));
          chk("win", 32'(bus.win), 32'(held[10]));
          chk("latency_edges", 32'(cyc - st - 1), 32'd30);
        end
      end else begin
        chk("hold_feedback", 32'(bus.feedback), 32'(held[9:0]));
        chk("hold_win", 32'(bus.win), 32'(held[10]));
      end
    end
    done_prev = bus.Done;
  end

  // Driver tasks.
  task automatic start_pulse(input logic [39:0] g, input logic [39:0] a,
                             input logic [9:0] fb, input logic w);
    @(negedge Clk);
    bus.guess  = g;
    bus.answer = a;
    bus.Start  = 1'b1;
    exp_q.push_back({w, fb});
    start_q.push_back(cyc);
    @(negedge Clk);
    bus.Start = 1'b0;
    chk("busy_after_start", 32'({bus.Busy, bus.q_G}), 32'b11);
  endtask

  task automatic wait_done();
    int k = 0;
    while (!bus.Done && k < 100) begin
      @(negedge Clk);
      k++;
    end
    if (!bus.Done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=0 expected=1 at cycle %0d", cyc);
    end
  endtask

  task automatic ack_after(input int d, input logic [9:0] fb);
    repeat (d) @(negedge Clk);
    bus.Ack = 1'b1;
    @(negedge Clk);
    bus.Ack = 1'b0;
    chk("idle_after_ack", 32'({bus.q_I, bus.Done, bus.win, bus.Busy}), 32'b1000);
    chk("idle_keeps_feedback", 32'(bus.feedback), 32'(fb));
  endtask

  task automatic score(input logic [39:0] g, input logic [39:0] a,
                       input logic [9:0] fb, input logic w);
    start_pulse(g, a, fb, w);
    wait_done();
    ack_after(1, fb);
  endtask

  initial begin
    bus.Start  = 1'b0;
    bus.Ack    = 1'b0;
    bus.guess  = '0;
    bus.answer = '0;
    repeat (2) @(negedge Clk);
    chk("reset_flags", 32'({bus.q_I, bus.q_G, bus.q_Y, bus.q_Done, bus.Busy, bus.Done, bus.win}),
        32'b1000000);
    chk("reset_feedback", 32'(bus.feedback), 32'd0);
    reset = 1'b1;

    // Directed vectors, expected values worked by hand.
    score("CRANE", "CRANE", 10'b10_10_10_10_10, 1'b1);
    score("EERIE", "CRANE", 10'b00_00_01_00_10, 1'b0);
    score("BABES", "ABBEY", 10'b01_01_10_10_00, 1'b0);
    score("MOIST", "CRANE", 10'b00_00_00_00_00, 1'b0);
    score("RANEC", "CRANE", 10'b01_01_01_01_01, 1'b0);
    score("BBBBB", "ABBEY", 10'b00_10_10_00_00, 1'b0);

    // Start held high, inputs changed mid yellow pass, Ack withheld for 10 cycles.
    @(negedge Clk);
    bus.guess  = "BABES";
    bus.answer = "ABBEY";
    bus.Start  = 1'b1;
    exp_q.push_back({1'b0, 10'b01_01_10_10_00});
    start_q.push_back(cyc);
    repeat (20) @(negedge Clk);
    chk("mid_qy_state", 32'(bus.q_Y), 32'd1);
    bus.guess  = "ABBEY";
    bus.answer = "CRANE";
    wait_done();
    repeat (10) @(negedge Clk);
    chk("done_held", 32'({bus.Done, bus.q_Done}), 32'b11);
    bus.Ack   = 1'b1;
    bus.Start = 1'b0;
    @(negedge Clk);
    bus.Ack = 1'b0;
    chk("held_start_idle", 32'({bus.q_I, bus.Done}), 32'b10);
    repeat (5) @(negedge Clk);
    chk("no_second_result", 32'({bus.q_I, bus.Busy}), 32'b10);

    // Start and Ack together in Done: Ack wins, the following Start is accepted.
    start_pulse("CRANE", "CRANE", 10'b10_10_10_10_10, 1'b1);
    wait_done();
    bus.Ack    = 1'b1;
    bus.Start  = 1'b1;
    bus.guess  = "EERIE";
    bus.answer = "CRANE";
    @(negedge Clk);
    chk("ack_beats_start", 32'({bus.q_I, bus.Busy}), 32'b10);
    bus.Ack = 1'b0;
    exp_q.push_back({1'b0, 10'b00_00_01_00_10});
    start_q.push_back(cyc);
    @(negedge Clk);
    bus.Start = 1'b0;
    chk("start_after_ack", 32'(bus.q_G), 32'd1);
    wait_done();
    ack_after(0, 10'b00_00_01_00_10);

    // Reset in the 15th yellow-pass cycle, then a clean request.
    start_pulse("EERIE", "CRANE", 10'b00_00_01_00_10, 1'b0);
    repeat (19) @(negedge Clk);
    chk("pre_reset_qy", 32'(bus.q_Y), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_flags",
        32'({bus.q_I, bus.q_G, bus.q_Y, bus.q_Done, bus.Busy, bus.Done, bus.win}), 32'b1000000);
    chk("async_reset_feedback", 32'(bus.feedback), 32'd0);
    exp_q.delete();
    start_q.delete();
    @(negedge Clk);
    reset = 1'b1;
    score("BABES", "ABBEY", 10'b01_01_10_10_00, 1'b0);

    repeat (3) @(negedge Clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
